// File: rtl/mips_pkg.sv
// Shared constants, state encoding and address helper for the 16-bit MIPS core.
// The instruction store and the PC both use the same window limit.
package mips_pkg;
    localparam int INSTR_W    = 16;
    localparam int BYTE_W     = 8;
    localparam int PC_W       = 16;
    localparam int IMEM_DEPTH = 16;

    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        RUN     = 2'd3
    } load_state_e;

    // A fetch is legal only for even byte addresses inside the program window.
    function automatic logic fetch_addr_ok(input logic [PC_W-1:0] addr, input int depth);
        return (addr[0] == 1'b0) && (addr <= PC_W'(2 * depth - 2));
    endfunction
endpackage

// File: rtl/imem_byte_loader.sv
// Byte-serial program loader: assembles little-endian byte pairs into words
// and produces the write strobe for the instruction store.
module imem_byte_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [BYTE_W-1:0]        load_byte,
    output logic                     load_busy,
    output logic                     load_done,
    output logic [$clog2(DEPTH)-1:0] load_ptr,
    output logic                     run_active,
    output logic                     wr_en,
    output logic [INSTR_W-1:0]       wr_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    load_state_e       state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [BYTE_W-1:0] lo_hold_q, lo_hold_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lo_hold_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lo_hold_q <= lo_hold_d;
            done_q    <= done_d;
        end
    end

    // A restart wins over everything, including a byte arriving the same cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lo_hold_d = lo_hold_q;
        done_d    = 1'b0;
        if (load_start) begin
            state_d = LOAD_LO;
            ptr_d   = '0;
        end else begin
            case (state_q)
                LOAD_LO: begin
                    if (load_valid) begin
                        lo_hold_d = load_byte;
                        state_d   = LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    if (load_valid) begin
                        if (ptr_q == LAST_PTR) begin
                            state_d = RUN;
                            ptr_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + AW'(1);
                            state_d = LOAD_LO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_busy  = (state_q == LOAD_LO) || (state_q == LOAD_HI);
        run_active = (state_q == RUN);
        wr_en      = (state_q == LOAD_HI) && load_valid && !load_start;
        wr_data    = {load_byte, lo_hold_q};
        load_done  = done_q;
        load_ptr   = ptr_q;
    end
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory for the single-cycle core: loader-filled word store with a
// zero-latency fetch mux and out-of-window address flagging.
module imem_fetch_unit #(
    parameter int                             DEPTH    = mips_pkg::IMEM_DEPTH,
    parameter logic [mips_pkg::INSTR_W-1:0]   NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [mips_pkg::BYTE_W-1:0]    load_byte,
    output logic                           load_busy,
    output logic                           load_done,
    output logic [$clog2(DEPTH)-1:0]       load_ptr,
    input  logic [mips_pkg::PC_W-1:0]      pc_addr,
    output logic [mips_pkg::INSTR_W-1:0]   instr,
    output logic                           fetch_ready,
    output logic                           addr_err
);
    localparam int AW = $clog2(DEPTH);

    logic [mips_pkg::INSTR_W-1:0] mem_q [DEPTH];
    logic [mips_pkg::INSTR_W-1:0] mem_d [DEPTH];
    logic                         wr_en;
    logic [mips_pkg::INSTR_W-1:0] wr_data;
    logic [AW-1:0]                fetch_idx;
    logic                         addr_ok;

    imem_byte_loader #(
        .DEPTH (DEPTH)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_ptr   (load_ptr),
        .run_active (fetch_ready),
        .wr_en      (wr_en),
        .wr_data    (wr_data)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[load_ptr] = wr_data;
        end
    end

    // Reset wipes the store so a partial program can never be fetched later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        fetch_idx = pc_addr[AW:1];
        addr_ok   = mips_pkg::fetch_addr_ok(pc_addr, DEPTH);
        instr     = NOP_WORD;
        addr_err  = 1'b0;
        if (fetch_ready) begin
            if (addr_ok) begin
                instr = mem_q[fetch_idx];
            end else begin
                addr_err = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: fixed fetch table, hand-written
// restart/reset sequences and a randomized phase against a byte-count model.
module tb_imem_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_busy;
    logic        load_done;
    logic [3:0]  load_ptr;
    logic [15:0] pc_addr;
    logic [15:0] instr;
    logic        fetch_ready;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: counts bytes of the current load instead of tracking states.
    logic [15:0] m_mem [16];
    logic        m_loading;
    logic        m_ready;
    logic        m_done;
    logic [7:0]  m_lo;
    int          m_cnt;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] exp_instr;
        logic        exp_err;
    } fetch_vec_t;

    fetch_vec_t vecs [9];

    imem_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_ptr    (load_ptr),
        .pc_addr     (pc_addr),
        .instr       (instr),
        .fetch_ready (fetch_ready),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_loading = 1'b0;
        m_ready   = 1'b0;
        m_done    = 1'b0;
        m_lo      = 8'h00;
        m_cnt     = 0;
    endtask

    task automatic modelStep(input logic start, input logic valid, input logic [7:0] b);
        m_done = 1'b0;
        if (start) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_cnt     = 0;
        end else if (m_loading && valid) begin
            if (m_cnt % 2 == 0) m_lo = b;
            else m_mem[m_cnt / 2] = {b, m_lo};
            m_cnt++;
            if (m_cnt == 32) begin
                m_loading = 1'b0;
                m_ready   = 1'b1;
                m_done    = 1'b1;
                m_cnt     = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] exp_instr;
        logic        exp_err;
        exp_instr = 16'h0000;
        exp_err   = 1'b0;
        if (m_ready) begin
            if (pc_addr[0] || pc_addr > 16'd30) exp_err = 1'b1;
            else exp_instr = m_mem[int'(pc_addr >> 1)];
        end
        checkVal({tag, ".load_busy"},   32'(load_busy),   32'(m_loading));
        checkVal({tag, ".load_done"},   32'(load_done),   32'(m_done));
        checkVal({tag, ".load_ptr"},    32'(load_ptr),    32'(m_cnt / 2));
        checkVal({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(m_ready));
        checkVal({tag, ".instr"},       32'(instr),       32'(exp_instr));
        checkVal({tag, ".addr_err"},    32'(addr_err),    32'(exp_err));
    endtask

    task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] b,
                                 input string tag);
        load_start = start;
        load_valid = valid;
        load_byte  = b;
        modelStep(start, valid, b);
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_valid = 1'b0;
        checkOutput(tag);
    endtask

    task automatic doReset(input int n);
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("reset");
    endtask

    task automatic loadProgram(input logic [15:0] base, input bit gapped, input string tag);
        logic [15:0] w;
        applyStimulus(1'b1, 1'b0, 8'h00, tag);
        for (int k = 0; k < 16; k++) begin
            w = base + 16'(k);
            for (int h = 0; h < 2; h++) begin
                if (gapped) begin
                    repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 8'($urandom), tag);
                end
                applyStimulus(1'b0, 1'b1, (h == 0) ? w[7:0] : w[15:8], tag);
            end
        end
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < 9; i++) begin
            pc_addr = vecs[i].pc;
            #1;
            checkVal($sformatf("%s.instr@%0d", tag, vecs[i].pc), 32'(instr), 32'(vecs[i].exp_instr));
            checkVal($sformatf("%s.err@%0d", tag, vecs[i].pc), 32'(addr_err), 32'(vecs[i].exp_err));
        end
    endtask

    initial begin
        int done_pulses;

        vecs[0] = '{16'd0,      16'h1000, 1'b0};
        vecs[1] = '{16'd30,     16'h100F, 1'b0};
        vecs[2] = '{16'd6,      16'h1003, 1'b0};
        vecs[3] = '{16'd32,     16'h0000, 1'b1};
        vecs[4] = '{16'd5,      16'h0000, 1'b1};
        vecs[5] = '{16'd28,     16'h100E, 1'b0};
        vecs[6] = '{16'd31,     16'h0000, 1'b1};
        vecs[7] = '{16'hFFFE,   16'h0000, 1'b1};
        vecs[8] = '{16'd2,      16'h1001, 1'b0};

        pc_addr = 16'd0;
        doReset(2);
        checkVal("t1.instr", 32'(instr), 32'h0);
        checkVal("t1.ready", 32'(fetch_ready), 32'h0);

        // Full load; load_done must fire exactly once, together with fetch_ready.
        done_pulses = 0;
        load_start  = 1'b1;
        modelStep(1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            logic [15:0] w;
            w = 16'h1000 + 16'(k / 2);
            load_valid = 1'b1;
            load_byte  = (k % 2 == 0) ? w[7:0] : w[15:8];
            modelStep(1'b0, 1'b1, load_byte);
            @(posedge clk); #1;
            load_valid = 1'b0;
            if (load_done) done_pulses++;
            checkOutput("t2");
        end
        checkVal("t2.done_after_last", 32'(load_done), 32'h1);
        checkVal("t2.ready_after_last", 32'(fetch_ready), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, "t2.idle");
        if (load_done) done_pulses++;
        checkVal("t2.done_pulses", 32'(done_pulses), 32'd1);
        runTable("t2");

        loadProgram(16'h1000, 1'b1, "t3");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), "t3.run");
        checkVal("t3.load_ptr", 32'(load_ptr), 32'h0);
        runTable("t3");

        pc_addr = 16'd0;
        applyStimulus(1'b1, 1'b1, 8'hAA, "t5.start");
        checkVal("t5.busy", 32'(load_busy), 32'h1);
        checkVal("t5.ready", 32'(fetch_ready), 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h34, "t5.lo");
        applyStimulus(1'b0, 1'b1, 8'h12, "t5.hi");
        checkVal("t5.load_ptr", 32'(load_ptr), 32'h1);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(k), "t5.fill");
            applyStimulus(1'b0, 1'b1, 8'h20, "t5.fill");
        end
        pc_addr = 16'd0;
        #1;
        checkVal("t5.mem0", 32'(instr), 32'h1234);
        pc_addr = 16'd4;
        #1;
        checkVal("t5.mem2", 32'(instr), 32'h2002);

        applyStimulus(1'b1, 1'b0, 8'h00, "t6.start");
        for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 8'($urandom), "t6.bytes");
        doReset(1);
        checkVal("t6.busy", 32'(load_busy), 32'h0);
        for (int a = 0; a < 34; a += 3) begin
            pc_addr = 16'(a);
            #1;
            checkVal($sformatf("t6.instr@%0d", a), 32'(instr), 32'h0);
        end
        loadProgram(16'h1000, 1'b0, "t6.reload");
        runTable("t6");

        // Randomized traffic: restarts, gaps, stray bytes and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            pc_addr = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 299) == 0) begin
                doReset(1);
            end else begin
                applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
                              8'($urandom), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Instruction-memory responder for the 16-bit single-cycle MIPS core. It answers the program counter's byte-addressed fetch requests with 16-bit instruction words. It owns a byte-serial program loader FSM that fills the 16-word store from an external byte stream before the core runs. It also flags fetch addresses outside the program window.

Parameters:
DEPTH, 16, number of 16-bit instruction words (power of two); last valid byte address = 2*DEPTH-2 (30)
NOP_WORD, 16'h0000, word returned when no valid instruction is available

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  single-cycle pulse: begin (re)loading program from word 0
load_valid  input  1  load_byte carries a valid byte this cycle
load_byte  input  8  program byte stream, low byte of each word first
load_busy  output  1  loader in LOAD_LO or LOAD_HI
load_done  output  1  single-cycle pulse on the cycle the final high byte is written
load_ptr  output  4  index of word currently being assembled
pc_addr  input  16  byte address from the program counter
instr  output  16  instruction word for pc_addr
fetch_ready  output  1  store holds a complete program; instr is meaningful
addr_err  output  1  pc_addr outside 0..2*DEPTH-2 or odd, while fetch_ready=1

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, load_ptr=0, lo_hold=0, all DEPTH words=NOP_WORD. Outputs: load_busy=0, load_done=0, fetch_ready=0, instr=NOP_WORD, addr_err=0. Reset mid-load discards the partial program.
- FSM states: IDLE, LOAD_LO, LOAD_HI, RUN.
  - IDLE: load_start -> LOAD_LO, load_ptr=0.
  - LOAD_LO: load_valid -> lo_hold<=load_byte, go to LOAD_HI.
  - LOAD_HI: load_valid -> mem[load_ptr]<={load_byte,lo_hold}.
    - If load_ptr==DEPTH-1: go to RUN, pulse load_done, load_ptr wraps to 0.
    - Else: load_ptr+1, go to LOAD_LO.
  - RUN: load_start -> LOAD_LO, load_ptr=0, fetch_ready drops the next cycle. Stored words are kept until they are overwritten.
- load_start has priority. In any state, load_start restarts at LOAD_LO / ptr 0, and a load_valid byte in the same cycle is dropped.
- load_valid=0 holds the state; gaps between bytes are unlimited.
- load_valid outside LOAD_LO/LOAD_HI is ignored.
- load_done is registered and high for exactly one cycle.
- Fetch path:
  - Combinational, zero latency, to suit single-cycle execution.
  - Index = pc_addr[log2(DEPTH):1].
  - fetch_ready = (state==RUN), registered.
- When fetch_ready=0, instr=NOP_WORD and addr_err=0.
- When fetch_ready=1:
  - If pc_addr[0]==1 or pc_addr>2*DEPTH-2: addr_err=1, instr=NOP_WORD.
  - Else: instr=mem[index], addr_err=0.
- A fetch of a word during the same cycle it is written does not occur, because fetch_ready=0 whenever writes happen.

Decomposition:
- Shared package mips_pkg:
  - INSTR_W=16, BYTE_W=8, NOP_WORD.
  - State encoding constants: IDLE=2'd0, LOAD_LO=2'd1, LOAD_HI=2'd2, RUN=2'd3.
  - IMEM_DEPTH=16, shared with the PC wrap limit of 30.
- One natural sub-module: imem_byte_loader, containing the FSM, lo_hold, load_ptr and write-enable generation.
- The top level holds the array and the fetch mux.

Test Plan:
1. Reset then fetch -> rst 2 cycles, pc_addr=0 -> instr=16'h0000, fetch_ready=0, addr_err=0.
2. Full load -> load_start, then 32 bytes with word k = 16'h1000+k (lo byte first). Required:
   - load_done pulses once, one cycle after the 32nd byte edge.
   - fetch_ready=1 next cycle.
   - pc_addr=0 -> 16'h1000; pc_addr=30 -> 16'h100F; pc_addr=6 -> 16'h1003.
3. Gapped stream plus ignored bytes -> insert random load_valid=0 gaps, and send extra bytes while in RUN. Required: contents identical to test 2 and load_ptr=0.
4. Address errors in RUN -> pc_addr=32 -> addr_err=1, instr=0; pc_addr=5 -> addr_err=1; pc_addr=28 -> addr_err=0, instr=16'h100E.
5. Restart/priority -> in RUN, load_start with simultaneous load_valid byte 8'hAA. Required: byte dropped, state LOAD_LO, fetch_ready=0. Next two bytes 8'h34, 8'h12 -> mem[0]=16'h1234, load_ptr=1.
6. Reset mid-load -> after 9 bytes, rst=1. Required: state IDLE, load_busy=0, all fetches return 0. A subsequent full load behaves as in test 2.
